reg_bank: RTL and testbench

Parametrised successor to the single 16-bit load register. It holds DEPTH registers of WIDTH bits each, with one addressed operation port supporting hold, load, increment and clear. Two independent read ports are provided. A registered wrap pulse and per-register dirty flags are also output. It serves as the general-purpose register storage and counter bank for the CPU datapath.

---
 rtl/reg_bank.sv | 102 ++++++++++
 tb/tb_reg_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH registers with one hold/load/increment/clear port, two read ports, a wrap pulse and dirty flags.
// Latency: ops land on the next clock edge and reads are combinational. With READ_BYPASS_EN, reads forward the pending write.
// Backpressure: none. An op is accepted every cycle, and an op whose addr is out of range acts as hold.
module reg_bank #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  out_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  out_b,
    output logic              wrap,
    output logic [DEPTH-1:0]  dirty
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_dirty;
    logic             r_wrap;

    logic [DEPTH-1:0] w_sel;
    logic             w_addr_ok;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_inc;
    logic             w_carry;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // The decode loop only matches addresses below DEPTH, so out-of-range addresses select nothing and read back as zero.
    always_comb begin
        w_sel  = '0;
        w_old  = '0;
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                w_sel[i] = 1'b1;
                w_old    = r_mem[i];
            end
            if (raddr_a == ADDR_W'(i)) w_rd_a = r_mem[i];
            if (raddr_b == ADDR_W'(i)) w_rd_b = r_mem[i];
        end
    end

    assign w_addr_ok        = |w_sel;
    assign {w_carry, w_inc} = {1'b0, w_old} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_next = w_old;
        case (op)
            OP_LOAD: w_next = in;
            OP_INC:  w_next = w_inc;
            OP_CLR:  w_next = '0;
            default: w_next = w_old;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_dirty <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_addr_ok && (op == OP_INC) && w_carry;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel[i] && (op != OP_HOLD)) begin
                    r_mem[i]   <= w_next;
                    r_dirty[i] <= (op != OP_CLR);
                end
            end
        end
    end

`ifdef READ_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;

    // A matching read address implies it is in range, because w_addr_ok already requires addr < DEPTH.
    assign w_fwd_a = reset_n && w_addr_ok && (op != OP_HOLD) && (raddr_a == addr);
    assign w_fwd_b = reset_n && w_addr_ok && (op != OP_HOLD) && (raddr_b == addr);
    assign out_a   = w_fwd_a ? w_next : w_rd_a;
    assign out_b   = w_fwd_b ? w_next : w_rd_b;
`else
    assign out_a = w_rd_a;
    assign out_b = w_rd_b;
`endif

    assign wrap  = r_wrap;
    assign dirty = r_dirty;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank (DEPTH=6, so addresses 6 and 7 are out of range).
// Expected read data is queued as each read is issued and compared once the ports settle.
module tb_reg_bank;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 6;
    localparam int ADDR_W = 3;

    logic              clock;
    logic              reset_n;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  out_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  out_b;
    logic              wrap;
    logic [DEPTH-1:0]  dirty;

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n), .op(op), .addr(addr), .in(in),
        .raddr_a(raddr_a), .out_a(out_a), .raddr_b(raddr_b), .out_b(out_b),
        .wrap(wrap), .dirty(dirty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model storage has 8 entries; entries 6 and 7 are never written, so out-of-range reads model as zero.
    logic [WIDTH-1:0] m_mem [8];
    logic [DEPTH-1:0] m_dirty;
    logic             m_wrap;
    logic [WIDTH-1:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_dirty = '0;
        m_wrap  = 1'b0;
    endtask

    // Apply one op across a clock edge and update the model; returns 1 ns after the edge with op back at hold.
    task automatic do_op(input logic [1:0] o, input logic [2:0] a, input logic [15:0] d);
        op = o; addr = a; in = d;
        @(posedge clock);
        #1;
        m_wrap = 1'b0;
        if (a < 3'd6) begin
            case (o)
                2'b01: begin m_mem[a] = d; m_dirty[a] = 1'b1; end
                2'b10: begin
                    m_wrap     = (m_mem[a] == 16'hFFFF);
                    m_mem[a]   = m_mem[a] + 16'd1;
                    m_dirty[a] = 1'b1;
                end
                2'b11: begin m_mem[a] = '0; m_dirty[a] = 1'b0; end
                default: ;
            endcase
        end
        op = 2'b00;
    endtask

    task automatic set_reads(input logic [2:0] ra, input logic [2:0] rb);
        raddr_a = ra; raddr_b = rb;
        exp_q.push_back(m_mem[ra]);
        exp_q.push_back(m_mem[rb]);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset_n = 1'b0; op = 2'b00; addr = '0; in = '0; raddr_a = '0; raddr_b = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        set_reads(3'd0, 3'd7);
        e = exp_q.pop_front(); checks++;
        if (out_a !== e) begin errors++; $display("FAIL reset_out_a got %h want %h", out_a, e); end
        e = exp_q.pop_front(); checks++;
        if (out_b !== e) begin errors++; $display("FAIL reset_out_b got %h want %h", out_b, e); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        checks++;
        if (dirty !== 6'h00) begin errors++; $display("FAIL reset_dirty got %h want 00", dirty); end
    endtask

    task automatic test_load_dual_read();
        logic [15:0] e;
        @(posedge clock); #1;
        raddr_a = 3'd3;
        op = 2'b01; addr = 3'd3; in = 16'hABCD;
        #1;
`ifdef READ_BYPASS_EN
        e = 16'hABCD;
`else
        e = 16'h0000;
`endif
        checks++;
        if (out_a !== e) begin errors++; $display("FAIL load_cycle_read got %h want %h", out_a, e); end
        do_op(2'b01, 3'd3, 16'hABCD);
        do_op(2'b01, 3'd5, 16'h1234);
        set_reads(3'd3, 3'd5);
        e = exp_q.pop_front(); checks++;
        if (out_a !== e || e !== 16'hABCD) begin errors++; $display("FAIL load_out_a got %h want ABCD", out_a); end
        e = exp_q.pop_front(); checks++;
        if (out_b !== e || e !== 16'h1234) begin errors++; $display("FAIL load_out_b got %h want 1234", out_b); end
        checks++;
        if (dirty !== 6'h28) begin errors++; $display("FAIL load_dirty got %h want 28", dirty); end
    endtask

    task automatic test_increment_wrap();
        logic [15:0] e;
        do_op(2'b01, 3'd2, 16'hFFFE);
        do_op(2'b10, 3'd2, 16'h0000);
        set_reads(3'd2, 3'd2);
        e = exp_q.pop_front(); void'(exp_q.pop_front()); checks++;
        if (out_a !== 16'hFFFF) begin errors++; $display("FAIL inc1_value got %h want FFFF", out_a); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL inc1_wrap got %b want 0", wrap); end
        do_op(2'b10, 3'd2, 16'h0000);
        set_reads(3'd2, 3'd3);
        e = exp_q.pop_front(); checks++;
        if (out_a !== e || e !== 16'h0000) begin errors++; $display("FAIL inc2_value got %h want 0000", out_a); end
        void'(exp_q.pop_front());
        checks++;
        if (wrap !== 1'b1) begin errors++; $display("FAIL inc2_wrap got %b want 1", wrap); end
        do_op(2'b00, 3'd2, 16'h0000);
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse_end got %b want 0", wrap); end
    endtask

    task automatic test_back_to_back();
        do_op(2'b01, 3'd4, 16'hFFFF);
        do_op(2'b01, 3'd0, 16'hFFFF);
        do_op(2'b10, 3'd4, 16'h0000);
        checks++;
        if (wrap !== 1'b1) begin errors++; $display("FAIL b2b_wrap1 got %b want 1", wrap); end
        do_op(2'b10, 3'd0, 16'h0000);
        checks++;
        if (wrap !== 1'b1) begin errors++; $display("FAIL b2b_wrap2 got %b want 1", wrap); end
        do_op(2'b10, 3'd0, 16'h0000);
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL b2b_wrap3 got %b want 0", wrap); end
    endtask

    task automatic test_clear();
        logic [15:0] e;
        do_op(2'b10, 3'd2, 16'h0000);
        do_op(2'b11, 3'd2, 16'h0000);
        checks++;
        if (dirty[2] !== 1'b0 || dirty !== m_dirty) begin errors++; $display("FAIL clear_dirty got %h want %h", dirty, m_dirty); end
        for (int r = 0; r < 6; r += 2) begin
            set_reads(3'(r), 3'(r + 1));
            e = exp_q.pop_front(); checks++;
            if (out_a !== e) begin errors++; $display("FAIL clear_reg%0d got %h want %h", r, out_a, e); end
            e = exp_q.pop_front(); checks++;
            if (out_b !== e) begin errors++; $display("FAIL clear_reg%0d got %h want %h", r + 1, out_b, e); end
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] e;
        logic [5:0]  d0;
        d0 = m_dirty;
        do_op(2'b01, 3'd7, 16'h5555);
        do_op(2'b10, 3'd6, 16'h0000);
        checks++;
        if (dirty !== d0) begin errors++; $display("FAIL oor_dirty got %h want %h", dirty, d0); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL oor_wrap got %b want 0", wrap); end
        set_reads(3'd7, 3'd6);
        e = exp_q.pop_front(); checks++;
        if (out_a !== e || e !== 16'h0000) begin errors++; $display("FAIL oor_read_a got %h want 0000", out_a); end
        e = exp_q.pop_front(); checks++;
        if (out_b !== e) begin errors++; $display("FAIL oor_read_b got %h want %h", out_b, e); end
        for (int r = 0; r < 6; r++) begin
            set_reads(3'(r), 3'(5 - r));
            e = exp_q.pop_front(); checks++;
            if (out_a !== e) begin errors++; $display("FAIL oor_keep_reg%0d got %h want %h", r, out_a, e); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_random();
        logic [15:0] e;
        logic [1:0]  o;
        logic [2:0]  a;
        logic [15:0] d;
        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom_range(0, 3));
            a = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            do_op(o, a, d);
            set_reads(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            e = exp_q.pop_front(); checks++;
            if (out_a !== e) begin errors++; $display("FAIL rand%0d_out_a got %h want %h", n, out_a, e); end
            e = exp_q.pop_front(); checks++;
            if (out_b !== e) begin errors++; $display("FAIL rand%0d_out_b got %h want %h", n, out_b, e); end
            checks++;
            if (wrap !== m_wrap) begin errors++; $display("FAIL rand%0d_wrap got %b want %b", n, wrap, m_wrap); end
            checks++;
            if (dirty !== m_dirty) begin errors++; $display("FAIL rand%0d_dirty got %h want %h", n, dirty, m_dirty); end
        end
    endtask

    task automatic test_async_reset();
        do_op(2'b01, 3'd1, 16'h00FF);
        raddr_a = 3'd1;
        op = 2'b10; addr = 3'd1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_a !== 16'h0000) begin errors++; $display("FAIL arst_out_a got %h want 0000", out_a); end
        checks++;
        if (dirty !== 6'h00) begin errors++; $display("FAIL arst_dirty got %h want 00", dirty); end
        @(posedge clock);
        #1;
        op = 2'b00;
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (out_a !== 16'h0000) begin errors++; $display("FAIL arst_after_out_a got %h want 0000", out_a); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL arst_after_wrap got %b want 0", wrap); end
        checks++;
        if (dirty !== 6'h00) begin errors++; $display("FAIL arst_after_dirty got %h want 00", dirty); end
        do_op(2'b10, 3'd1, 16'h0000);
        checks++;
        if (out_a !== 16'h0001) begin errors++; $display("FAIL arst_resume got %h want 0001", out_a); end
    endtask

    initial begin
        test_reset();
        test_load_dual_read();
        test_increment_wrap();
        test_back_to_back();
        test_clear();
        test_out_of_range();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
